rotation_tracker: RTL and testbench
===================================

Name: rotation_tracker

Overview:
Downstream consumer of the per-cycle quadrature direction code (11 = clockwise step, 00 = anticlockwise step, 01 = still, 10 = unknown/illegal transition). Accumulates angular position modulo one revolution, a signed revolution count, a windowed step-rate (speed) measurement, and a motion status with stall timeout. Escalates repeated illegal transitions into a sticky fault that freezes tracking until software clears it.

Parameters:
COUNTS_PER_REV, 8, steps per mechanical revolution (>= 2)
POS_W, 8, position width; must satisfy 2^POS_W >= COUNTS_PER_REV
REV_W, 8, signed revolution counter width
WINDOW_CYCLES, 16, speed measurement window length in clk cycles (>= 2)
SPD_W, 8, speed output width, saturating
STALL_CYCLES, 4, consecutive non-step cycles before motion reports still
FAULT_THRESH, 3, consecutive unknown codes that raise fault (>= 1)
ERR_W, 8, total-unknown counter width, saturating

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dir_code  in  2  direction code from detector, sampled every cycle
zero_pos  in  1  synchronous preset: position and revolutions to 0
clear_fault  in  1  clears sticky fault, returns to TRACK
position  out  POS_W  current step within revolution, 0..COUNTS_PER_REV-1
revolutions  out  REV_W  signed revolution count, two's-complement wrap
speed  out  SPD_W  steps (either direction) counted in last completed window
speed_valid  out  1  one-cycle pulse when speed updates
motion  out  2  11 CW, 00 CCW, 01 still, 10 faulted
fault  out  1  sticky fault flag
err_count  out  ERR_W  total unknown codes since reset, saturating

Behaviour:
- Reset (clk edge with reset=1): all outputs 0 except motion=01; state TRACK; window, stall, consecutive-unknown counters 0.
- All outputs registered; response to dir_code sampled at edge N visible after edge N.
- States: TRACK, FAULT.
- TRACK, code 11: position+1; if position==COUNTS_PER_REV-1, position->0 and revolutions+1. motion->11; stall counter->0; consecutive-unknown->0.
- TRACK, code 00: position-1; if position==0, position->COUNTS_PER_REV-1 and revolutions-1. motion->00; stall->0; consec->0.
- TRACK, code 01: stall counter +1 (saturate at STALL_CYCLES); when it reaches STALL_CYCLES motion->01. consec->0.
- Any state, code 10: err_count +1 (saturate at all-ones). In TRACK: consec+1, stall+1; when consec reaches FAULT_THRESH go to FAULT in same edge: fault=1, motion=10.
- FAULT: position, revolutions, motion frozen; steps ignored; speed window keeps running but counts no steps (speed reports 0 after the next full window). Exit only via clear_fault.
- clear_fault in FAULT: ->TRACK, fault=0, motion=01, consec=0, stall=0; code sampled that cycle is ignored except err_count. clear_fault in TRACK: consec->0, no other effect.
- zero_pos: position=0, revolutions=0; wins over a simultaneous step in the same cycle. Honoured in both states.
- Speed window: counter 0..WINDOW_CYCLES-1 free-running from reset. Step counter increments on 11/00 in TRACK, saturating at 2^SPD_W-1. On the cycle window counter == WINDOW_CYCLES-1: speed <= step count including this cycle's step, speed_valid=1 for one cycle, step counter->0, window->0.
- Reset mid-operation overrides everything, including fault, zero_pos, clear_fault.

Decomposition:
- Shared package rotation_pkg: direction code constants (DIR_CW=2'b11, DIR_CCW=2'b00, DIR_STILL=2'b01, DIR_UNKNOWN=2'b10), tracker state enum (TRACK, FAULT).
- One sub-module: rate_window (window counter, saturating step counter, speed latch, speed_valid pulse).

Test Plan:
- Reset then 10 cycles of 11 -> position 0..7,0,1; revolutions 1 after 8th step; motion 11 after first step.
- Hold position 0, apply one 00 -> position 7, revolutions -1 (8'hFF); then 4 cycles of 01 -> motion 01 after the 4th.
- 16-cycle window with 5 CW + 3 CCW steps -> speed 8, speed_valid single pulse at window end; next window of all 01 -> speed 0.
- Codes 10,10,01,10,10,10 -> no fault after first pair (consec reset by 01), fault=1, motion=10 after third consecutive 10; err_count 5; further 11 codes leave position unchanged.
- In FAULT assert clear_fault with dir_code=11 -> fault 0, motion 01, position unchanged; next 11 increments position.
- zero_pos with simultaneous 11 at position 5 -> position 0, revolutions 0; reset asserted during FAULT -> all outputs return to reset values.

Source files
------------

// File: rtl/rotation_tracker_pkg.sv
// Shared definitions for the rotation tracker: the direction codes coming
// from the quadrature detector, the motion status encoding and the tracker
// state enum.
package rotation_pkg;

    localparam logic [1:0] DIR_CW      = 2'b11;
    localparam logic [1:0] DIR_CCW     = 2'b00;
    localparam logic [1:0] DIR_STILL   = 2'b01;
    localparam logic [1:0] DIR_UNKNOWN = 2'b10;

    // Motion status reuses the direction encoding; 10 means faulted.
    localparam logic [1:0] MOTION_FAULT = 2'b10;

    typedef enum logic {
        TRACK = 1'b0,
        FAULT = 1'b1
    } track_state_t;

endpackage

// File: rtl/rotation_tracker_rate_window.sv
// Windowed step-rate measurement: a free-running window counter, a
// saturating step counter and a latched speed value with a one-cycle
// update pulse at the end of each window.
module rate_window #(
    parameter int WINDOW_CYCLES = 16,
    parameter int SPD_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    output logic [SPD_W-1:0] speed,
    output logic             speed_valid
);

    localparam int WIN_W = $clog2(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    logic [WIN_W-1:0] win_cnt;
    logic [SPD_W-1:0] step_cnt;
    logic [SPD_W-1:0] step_total;

    // Step count including this cycle's step, saturating at all-ones.
    always_comb begin
        step_total = step_cnt;
        if (step && (step_cnt != '1)) begin
            step_total = step_cnt + 1'b1;
        end
    end

    // Window bookkeeping: latch the count and pulse valid on the last cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt     <= '0;
            step_cnt    <= '0;
            speed       <= '0;
            speed_valid <= 1'b0;
        end else if (win_cnt == WIN_LAST) begin
            win_cnt     <= '0;
            step_cnt    <= '0;
            speed       <= step_total;
            speed_valid <= 1'b1;
        end else begin
            win_cnt     <= win_cnt + 1'b1;
            step_cnt    <= step_total;
            speed_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rotation_tracker.sv
// Rotation tracker: turns per-cycle direction codes into position within a
// revolution, a signed revolution count, motion status with stall timeout,
// a windowed speed, and a sticky fault on repeated illegal transitions.
module rotation_tracker #(
    parameter int COUNTS_PER_REV = 8,
    parameter int POS_W          = 8,
    parameter int REV_W          = 8,
    parameter int WINDOW_CYCLES  = 16,
    parameter int SPD_W          = 8,
    parameter int STALL_CYCLES   = 4,
    parameter int FAULT_THRESH   = 3,
    parameter int ERR_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       dir_code,
    input  logic             zero_pos,
    input  logic             clear_fault,
    output logic [POS_W-1:0] position,
    output logic [REV_W-1:0] revolutions,
    output logic [SPD_W-1:0] speed,
    output logic             speed_valid,
    output logic [1:0]       motion,
    output logic             fault,
    output logic [ERR_W-1:0] err_count
);

    import rotation_pkg::*;

    localparam int STALL_W  = $clog2(STALL_CYCLES + 1);
    localparam int CONSEC_W = $clog2(FAULT_THRESH + 1);
    localparam logic [POS_W-1:0]    POS_MAX    = POS_W'(COUNTS_PER_REV - 1);
    localparam logic [STALL_W-1:0]  STALL_MAX  = STALL_W'(STALL_CYCLES);
    localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(FAULT_THRESH);

    track_state_t        state, state_next;
    logic [POS_W-1:0]    pos_next;
    logic [REV_W-1:0]    rev_next;
    logic [1:0]          motion_next;
    logic                fault_next;
    logic [ERR_W-1:0]    err_next;
    logic [STALL_W-1:0]  stall_cnt, stall_next, stall_sat;
    logic [CONSEC_W-1:0] consec_cnt, consec_next;
    logic                step;

    // State and all tracked outputs are registered; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= TRACK;
            position    <= '0;
            revolutions <= '0;
            motion      <= DIR_STILL;
            fault       <= 1'b0;
            err_count   <= '0;
            stall_cnt   <= '0;
            consec_cnt  <= '0;
        end else begin
            state       <= state_next;
            position    <= pos_next;
            revolutions <= rev_next;
            motion      <= motion_next;
            fault       <= fault_next;
            err_count   <= err_next;
            stall_cnt   <= stall_next;
            consec_cnt  <= consec_next;
        end
    end

    // Next-state and next-output logic for the TRACK/FAULT machine.
    always_comb begin
        state_next  = state;
        pos_next    = position;
        rev_next    = revolutions;
        motion_next = motion;
        fault_next  = fault;
        err_next    = err_count;
        stall_next  = stall_cnt;
        consec_next = consec_cnt;
        step        = 1'b0;
        stall_sat   = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + 1'b1;

        if ((dir_code == DIR_UNKNOWN) && (err_count != '1)) begin
            err_next = err_count + 1'b1;
        end

        case (state)
            TRACK: begin
                case (dir_code)
                    DIR_CW: begin
                        step        = 1'b1;
                        motion_next = DIR_CW;
                        stall_next  = '0;
                        consec_next = '0;
                        if (position == POS_MAX) begin
                            pos_next = '0;
                            rev_next = revolutions + 1'b1;
                        end else begin
                            pos_next = position + 1'b1;
                        end
                    end
                    DIR_CCW: begin
                        step        = 1'b1;
                        motion_next = DIR_CCW;
                        stall_next  = '0;
                        consec_next = '0;
                        if (position == '0) begin
                            pos_next = POS_MAX;
                            rev_next = revolutions - 1'b1;
                        end else begin
                            pos_next = position - 1'b1;
                        end
                    end
                    DIR_STILL: begin
                        stall_next  = stall_sat;
                        consec_next = '0;
                        if (stall_sat == STALL_MAX) begin
                            motion_next = DIR_STILL;
                        end
                    end
                    default: begin
                        stall_next  = stall_sat;
                        consec_next = consec_cnt + 1'b1;
                        if (stall_sat == STALL_MAX) begin
                            motion_next = DIR_STILL;
                        end
                    end
                endcase

                if (clear_fault) begin
                    consec_next = '0;
                end else if (consec_next == CONSEC_MAX) begin
                    state_next  = FAULT;
                    fault_next  = 1'b1;
                    motion_next = MOTION_FAULT;
                end
            end
            FAULT: begin
                if (clear_fault) begin
                    state_next  = TRACK;
                    fault_next  = 1'b0;
                    motion_next = DIR_STILL;
                    consec_next = '0;
                    stall_next  = '0;
                end
            end
            default: begin
                state_next = TRACK;
            end
        endcase

        if (zero_pos) begin
            pos_next = '0;
            rev_next = '0;
        end
    end

    rate_window #(
        .WINDOW_CYCLES(WINDOW_CYCLES),
        .SPD_W        (SPD_W)
    ) u_rate_window (
        .clk        (clk),
        .reset      (reset),
        .step       (step),
        .speed      (speed),
        .speed_valid(speed_valid)
    );

endmodule

// File: tb/tb_rotation_tracker.sv
// Directed testbench for rotation_tracker with hand-computed expectations.
module tb_rotation_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dir_code;
    logic       zero_pos;
    logic       clear_fault;
    logic [7:0] position;
    logic [7:0] revolutions;
    logic [7:0] speed;
    logic       speed_valid;
    logic [1:0] motion;
    logic       fault;
    logic [7:0] err_count;

    int vectors     = 0;
    int miscompares = 0;

    rotation_tracker dut (
        .clk        (clk),
        .reset      (reset),
        .dir_code   (dir_code),
        .zero_pos   (zero_pos),
        .clear_fault(clear_fault),
        .position   (position),
        .revolutions(revolutions),
        .speed      (speed),
        .speed_valid(speed_valid),
        .motion     (motion),
        .fault      (fault),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and return 1ns after the sampling edge.
    task automatic applyStimulus(input logic [1:0] code, input logic zp, input logic cf);
        dir_code    = code;
        zero_pos    = zp;
        clear_fault = cf;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_pos",    position,    0);
        checkOutput("rst_rev",    revolutions, 0);
        checkOutput("rst_speed",  speed,       0);
        checkOutput("rst_valid",  speed_valid, 0);
        checkOutput("rst_motion", motion,      2'b01);
        checkOutput("rst_fault",  fault,       0);
        checkOutput("rst_err",    err_count,   0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(2'b01, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0, 1'b0);
        checkResetState();
        reset = 1'b0;

        // Window 1 (cycles 1..16): ten CW steps, wrap at 8.
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(2'b11, 1'b0, 1'b0);
            checkOutput("cw_pos", position, i % 8);
            checkOutput("cw_rev", revolutions, (i >= 8) ? 1 : 0);
            checkOutput("cw_motion", motion, 2'b11);
        end
        // Cycle 11: preset to zero, cycle 12: CCW wrap below zero.
        applyStimulus(2'b01, 1'b1, 1'b0);
        checkOutput("zero_pos", position, 0);
        checkOutput("zero_rev", revolutions, 0);
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("ccw_wrap_pos", position, 7);
        checkOutput("ccw_wrap_rev", revolutions, 8'hFF);
        checkOutput("ccw_motion", motion, 2'b00);
        // Cycles 13..16: still codes, motion goes still after the 4th.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(2'b01, 1'b0, 1'b0);
            checkOutput("stall_motion", motion, (i == 4) ? 2'b01 : 2'b00);
            checkOutput("w1_valid", speed_valid, (i == 4) ? 1 : 0);
        end
        checkOutput("w1_speed", speed, 11);

        // Window 2 (cycles 17..32): 5 CW, 3 CCW, 8 still.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(2'b11, 1'b0, 1'b0);
            checkOutput("w2_cw_pos", position, (i - 1) % 8);
        end
        checkOutput("w2_rev", revolutions, 0);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(2'b00, 1'b0, 1'b0);
            checkOutput("w2_ccw_pos", position, 4 - i);
        end
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(2'b01, 1'b0, 1'b0);
            checkOutput("w2_valid", speed_valid, (i == 8) ? 1 : 0);
            checkOutput("w2_speed", speed, (i == 8) ? 8 : 11);
        end

        // Window 3 (cycles 33..48): all still.
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(2'b01, 1'b0, 1'b0);
            checkOutput("w3_valid", speed_valid, (i == 16) ? 1 : 0);
        end
        checkOutput("w3_speed", speed, 0);
        checkOutput("w3_motion", motion, 2'b01);
        checkOutput("w3_pos", position, 1);

        // Unknown codes: 10,10,01,10,10,10.
        applyStimulus(2'b10, 1'b0, 1'b0);
        applyStimulus(2'b10, 1'b0, 1'b0);
        checkOutput("pair_fault", fault, 0);
        checkOutput("pair_motion", motion, 2'b01);
        checkOutput("pair_err", err_count, 2);
        applyStimulus(2'b01, 1'b0, 1'b0);
        applyStimulus(2'b10, 1'b0, 1'b0);
        applyStimulus(2'b10, 1'b0, 1'b0);
        checkOutput("pre_fault", fault, 0);
        applyStimulus(2'b10, 1'b0, 1'b0);
        checkOutput("fault_set", fault, 1);
        checkOutput("fault_motion", motion, 2'b10);
        checkOutput("fault_err", err_count, 5);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b11, 1'b0, 1'b0);
        end
        checkOutput("frozen_pos", position, 1);
        checkOutput("frozen_motion", motion, 2'b10);
        checkOutput("frozen_fault", fault, 1);
        checkOutput("frozen_err", err_count, 5);

        // Clear fault with a simultaneous CW step, which is ignored.
        applyStimulus(2'b11, 1'b0, 1'b1);
        checkOutput("clr_fault", fault, 0);
        checkOutput("clr_motion", motion, 2'b01);
        checkOutput("clr_pos", position, 1);
        applyStimulus(2'b11, 1'b0, 1'b0);
        checkOutput("post_clr_pos", position, 2);
        checkOutput("post_clr_motion", motion, 2'b11);

        // Walk back to position 5 with revolutions -1, then preset with a step.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b00, 1'b0, 1'b0);
        end
        checkOutput("walk_pos", position, 5);
        checkOutput("walk_rev", revolutions, 8'hFF);
        applyStimulus(2'b11, 1'b1, 1'b0);
        checkOutput("zp_step_pos", position, 0);
        checkOutput("zp_step_rev", revolutions, 0);

        // Fault again, then reset with every other control asserted.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b10, 1'b0, 1'b0);
        end
        checkOutput("fault2_set", fault, 1);
        checkOutput("fault2_err", err_count, 8);
        reset = 1'b1;
        applyStimulus(2'b10, 1'b1, 1'b1);
        checkResetState();
        reset = 1'b0;
        applyStimulus(2'b11, 1'b0, 1'b0);
        checkOutput("after_rst_pos", position, 1);
        checkOutput("after_rst_motion", motion, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
